// File: rtl/ul_acc_if.sv
// Handshake/data bundle for ul_acc: operand side, result side and status.
// Build with UL_ACC_PARITY_EN defined to add the registered parity output.
interface ul_acc_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       s;
  logic             use_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic [CNT_W-1:0] op_count;
  logic             dbg_state;
`ifdef UL_ACC_PARITY_EN
  logic             parity;
`endif

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid && ready are both high; valid must not depend on ready.
  modport slave (
    input  in_valid, a, b, s, use_acc, acc_clr, out_ready,
`ifdef UL_ACC_PARITY_EN
    output parity,
`endif
    output in_ready, out_valid, out, zero, op_count, dbg_state
  );

  modport master (
    output in_valid, a, b, s, use_acc, acc_clr, out_ready,
`ifdef UL_ACC_PARITY_EN
    input  parity,
`endif
    input  in_ready, out_valid, out, zero, op_count, dbg_state
  );
endinterface

// File: rtl/ul_acc.sv
// Registered bitwise logic unit (AND/OR/XOR/NOT) with accumulator operand,
// one-entry output buffer and op counter. Optional parity: UL_ACC_PARITY_EN.
module ul_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic   clk,
  input  logic   reset,
  ul_acc_if.slave bus
);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] f;
  logic             accept;

  assign bus.in_ready = (state_q == ST_EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign opb          = bus.use_acc ? acc_q : bus.b;

  always_comb begin
    f = '0;
    case (bus.s)
      2'b00:   f = bus.a & opb;
      2'b01:   f = bus.a | opb;
      2'b10:   f = bus.a ^ opb;
      default: f = ~bus.a;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zero_d  = zero_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = ST_FULL;
      out_d   = f;
      zero_d  = (f == '0);
      acc_d   = f;
      cnt_d   = cnt_q + 1'b1;
    end else begin
      if (state_q == ST_FULL && bus.out_ready) state_d = ST_EMPTY;
      // A same-cycle accept already overwrote acc above, so clear only here.
      if (bus.acc_clr) acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      zero_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.op_count  = cnt_q;
  assign bus.dbg_state = state_q[0];

`ifdef UL_ACC_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset)       parity_q <= 1'b0;
    else if (accept) parity_q <= ^f;
  end

  assign bus.parity = parity_q;
`endif
endmodule

// File: tb/tb_ul_acc.sv
// Directed bench for ul_acc: a main instance (CNT_W=8) and a CNT_W=2 instance
// for counter wrap, mid-stall reset and parity.
module tb_ul_acc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ul_acc_if #(.WIDTH(8), .CNT_W(8)) bus0 ();
  ul_acc_if #(.WIDTH(8), .CNT_W(2)) bus1 ();

  ul_acc #(.WIDTH(8), .CNT_W(8)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  ul_acc #(.WIDTH(8), .CNT_W(2)) u1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] s, input logic ua);
    bus0.in_valid = v;
    bus0.a        = a;
    bus0.b        = b;
    bus0.s        = s;
    bus0.use_acc  = ua;
  endtask

  initial begin
    drive0(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    bus0.acc_clr   = 1'b0;
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = 8'h00;
    bus1.b         = 8'h00;
    bus1.s         = 2'b00;
    bus1.use_acc   = 1'b0;
    bus1.acc_clr   = 1'b0;
    bus1.out_ready = 1'b1;

    // Reset
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus0.out_valid), 32'h0);
    chk("rst_out", 32'(bus0.out), 32'h00);
    chk("rst_zero", 32'(bus0.zero), 32'h0);
    chk("rst_op_count", 32'(bus0.op_count), 32'h00);
    chk("rst_in_ready", 32'(bus0.in_ready), 32'h1);
    chk("rst_state", 32'(bus0.dbg_state), 32'h0);

    // Four ops, back to back
    drive0(1'b1, 8'hF0, 8'h3C, 2'b00, 1'b0);
    tick();
    chk("and_out", 32'(bus0.out), 32'h30);
    chk("and_valid", 32'(bus0.out_valid), 32'h1);
    chk("and_state", 32'(bus0.dbg_state), 32'h1);
`ifdef UL_ACC_PARITY_EN
    chk("and_parity", 32'(bus0.parity), 32'h0);
`endif
    bus0.s = 2'b01;
    tick();
    chk("or_out", 32'(bus0.out), 32'hFC);
    bus0.s = 2'b10;
    tick();
    chk("xor_out", 32'(bus0.out), 32'hCC);
    bus0.s = 2'b11;
    tick();
    chk("not_out", 32'(bus0.out), 32'h0F);
    chk("four_op_count", 32'(bus0.op_count), 32'h04);

    // Accumulator as operand B
    drive0(1'b1, 8'h0F, 8'h00, 2'b01, 1'b0);
    tick();
    chk("accl_out", 32'(bus0.out), 32'h0F);
    drive0(1'b1, 8'hFF, 8'h00, 2'b10, 1'b1);
    tick();
    chk("acc_xor_out", 32'(bus0.out), 32'hF0);
    chk("acc_xor_zero", 32'(bus0.zero), 32'h0);
    drive0(1'b1, 8'hF0, 8'h00, 2'b10, 1'b1);
    tick();
    chk("acc_zero_out", 32'(bus0.out), 32'h00);
    chk("acc_zero_flag", 32'(bus0.zero), 32'h1);

    // Drain then backpressure
    drive0(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    tick();
    chk("drain_valid", 32'(bus0.out_valid), 32'h0);
    chk("drain_out_hold", 32'(bus0.out), 32'h00);
    chk("drain_zero_hold", 32'(bus0.zero), 32'h1);
    drive0(1'b1, 8'hA5, 8'hFF, 2'b00, 1'b0);
    bus0.out_ready = 1'b0;
    tick();
    chk("bp_out", 32'(bus0.out), 32'hA5);
    chk("bp_in_ready", 32'(bus0.in_ready), 32'h0);
    drive0(1'b1, 8'h11, 8'h22, 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_out", 32'(bus0.out), 32'hA5);
      chk("bp_hold_valid", 32'(bus0.out_valid), 32'h1);
    end
    bus0.out_ready = 1'b1;
    tick();
    chk("bp_release_out", 32'(bus0.out), 32'h33);
    chk("bp_release_valid", 32'(bus0.out_valid), 32'h1);
    chk("bp_op_count", 32'(bus0.op_count), 32'h09);

    // acc_clr together with accept: accept uses old acc and wins the write
    drive0(1'b1, 8'hAA, 8'h00, 2'b01, 1'b0);
    tick();
    chk("load_aa", 32'(bus0.out), 32'hAA);
    drive0(1'b1, 8'h55, 8'h00, 2'b01, 1'b1);
    bus0.acc_clr = 1'b1;
    tick();
    chk("clr_accept_out", 32'(bus0.out), 32'hFF);
    bus0.acc_clr = 1'b0;
    drive0(1'b1, 8'h00, 8'h00, 2'b01, 1'b1);
    tick();
    chk("clr_accept_acc", 32'(bus0.out), 32'hFF);
    drive0(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    bus0.acc_clr = 1'b1;
    tick();
    bus0.acc_clr = 1'b0;
    drive0(1'b1, 8'h12, 8'h00, 2'b01, 1'b1);
    tick();
    chk("clr_alone", 32'(bus0.out), 32'h12);
    drive0(1'b1, 8'hFF, 8'h5A, 2'b11, 1'b0);
    tick();
    chk("not_zero_out", 32'(bus0.out), 32'h00);
    chk("not_zero_flag", 32'(bus0.zero), 32'h1);
    drive0(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    chk("final_op_count", 32'(bus0.op_count), 32'h0E);

    // Counter wrap on the CNT_W=2 instance
    bus1.in_valid = 1'b1;
    bus1.a = 8'h07;
    bus1.b = 8'h00;
    bus1.s = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    bus1.in_valid = 1'b0;
    chk("wrap_op_count", 32'(bus1.op_count), 32'h1);
    chk("wrap_out", 32'(bus1.out), 32'h07);
`ifdef UL_ACC_PARITY_EN
    chk("parity_07", 32'(bus1.parity), 32'h1);
`endif

    // Reset while stalled
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.a = 8'h01;
    tick();
    chk("stall_valid", 32'(bus1.out_valid), 32'h1);
    chk("stall_in_ready", 32'(bus1.in_ready), 32'h0);
    reset = 1'b1;
    tick();
    chk("midrst_valid", 32'(bus1.out_valid), 32'h0);
    chk("midrst_out", 32'(bus1.out), 32'h00);
    chk("midrst_op_count", 32'(bus1.op_count), 32'h0);
    reset = 1'b0;
    bus1.in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
